sink_rr_arbiter: RTL and testbench
==================================

Name: sink_rr_arbiter

Overview:
- Round-robin arbiter that shares one NoC sink port between NIN flit streams. Typical sources are several router outputs or tpg instances.
- Sits between the traffic sources and a single sink BFM. Uses valid/ready on both sides and has a one-entry registered output stage.
- Keeps a delivered-flit count and a destination-check flag. Raises done when the count reaches a threshold, which ends the simulation.

Parameters:
WIDTH, 32, flit width.
N, 16, number of NoC nodes.
N_ADDR_WIDTH, $clog2(N), router address field width.
NIN, 4, number of requesting inputs (>=1).
NODE, 15, router index whose flits this arbiter must receive; compared against each flit's dst field.
CNT_WIDTH, 16, width of the delivered-flit counter.
DONE_COUNT, 1000, number of delivered flits at which done asserts.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_in  input  NIN*WIDTH  flattened input flits; input i occupies bits [i*WIDTH +: WIDTH]
valid_in  input  NIN  per-input valid
ready_out  output  NIN  per-input ready (one-hot or zero)
data_out  output  WIDTH  flit to sink
valid_out  output  1  output flit valid
ready_in  input  1  sink ready
delivered  output  CNT_WIDTH  output handshakes since reset, saturating
dst_err  output  1  sticky; a forwarded flit had dst != NODE
done  output  1  sticky; delivered >= DONE_COUNT

Behaviour:
- Flit fields:
  - src = [WIDTH-1 -: N_ADDR_WIDTH]
  - dst = [WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH]
  - id = next 8 bits
  - payload = remaining LSBs
- The arbiter never modifies a flit.
- Reset values: valid_out=0, data_out=0, ready_out=0 (forced 0 while rst is high), rr pointer=0, delivered=0, dst_err=0, done=0.
- Reset mid-operation discards any buffered flit. No handshake completes in a reset cycle.
- State: out_full (the output register holds a flit) and ptr (0..NIN-1, the highest-priority input).
- can_accept = !out_full || ready_in. Accepting while draining in the same cycle is legal, giving full throughput.
- Grant (combinational):
  - If can_accept, g = first i with valid_in[i], searching ptr, ptr+1, ... mod NIN.
  - ready_out[g]=1; all other bits 0.
  - ready_out is all-zero if no input is valid or if !can_accept.
- Input transfer happens when valid_in[g] && ready_out[g]. On the next edge:
  - data_out <= data_in[g]
  - valid_out <= 1
  - ptr <= (g+1) mod NIN
  - if dst != NODE, dst_err <= 1
- Output transfer happens when valid_out && ready_in. If there is no simultaneous input transfer, valid_out <= 0 and data_out holds its last value.
- Latency: a flit accepted at edge k is presented on valid_out from edge k onward (one register stage). It is held stable until ready_in is seen.
- ptr changes only on a grant. With no requests it holds.
- Sources may drop valid_in without a transfer. The arbiter keeps no per-input request state.
- delivered increments on each output transfer and saturates at 2^CNT_WIDTH-1.
- done <= 1 when delivered reaches DONE_COUNT (including the increment edge). It stays high until reset.
- NIN=1: the block degenerates to a one-entry pipeline register with ptr fixed at 0.
- Fairness: with all inputs continuously valid and ready_in=1, the grant order is 0,1,...,NIN-1,0,... and each input gets exactly 1 of every NIN flits.

Test Plan:
- Reset mid-stream (rst pulsed 1 cycle while valid_out=1) -> valid_out=0, ready_out=0, delivered=0, done=0, dst_err=0 on the following cycle; the first grant after reset goes to the lowest valid index.
- NIN=4, all valid_in=4'b1111, ready_in=1, 12 cycles -> src/id sequence on data_out is 0,1,2,3 repeated 3 times; one flit per cycle; delivered=12.
- Only input 2 valid, ready_in=1 -> ready_out=4'b0100 every cycle; each flit appears 1 cycle after acceptance; ptr stays 3 after each grant.
- Backpressure: ready_in=0 for 5 cycles with inputs 0 and 1 valid -> exactly one flit is accepted (from input 0), then ready_out=0 while data_out is held stable; when ready_in returns to 1, input 1 is granted in the same cycle as the drain.
- Flit with dst=3 while NODE=15 -> dst_err=1 one edge after acceptance and stays 1; later correct flits do not clear it.
- DONE_COUNT=5 with a continuous stream -> done rises on the edge of the 5th output handshake and stays 1 after the inputs go idle.

Source files
------------

// File: rtl/sink_rr_arbiter.sv
// sink_rr_arbiter: round-robin merge of NIN flit streams into one registered sink port with delivery count and dst check
module sink_rr_arbiter #(
  parameter int WIDTH = 32,
  parameter int N = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int NIN = 4,
  parameter int NODE = 15,
  parameter int CNT_WIDTH = 16,
  parameter int DONE_COUNT = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NIN*WIDTH-1:0] data_in,
  input  logic [NIN-1:0]       valid_in,
  output logic [NIN-1:0]       ready_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNT_WIDTH-1:0] delivered,
  output logic                 dst_err,
  output logic                 done
);
  localparam int PW = NIN > 1 ? $clog2(NIN) : 1;
  logic [PW-1:0] ptr, g, j;
  logic hit, can_accept, in_xfer, out_xfer;
  logic [WIDTH-1:0] sel;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  always_comb begin
    hit = 1'b0;
    g = ptr;
    j = ptr;
    for (int k = NIN - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NIN);
      if (valid_in[j]) begin
        hit = 1'b1;
        g = j;
      end
    end
  end
  assign can_accept = !valid_out || ready_in;
  assign ready_out = (hit && can_accept && !rst) ? NIN'(1) << g : '0;
  assign in_xfer = |ready_out;
  assign out_xfer = valid_out && ready_in;
  assign sel = data_in[int'(g)*WIDTH +: WIDTH];
  assign cnt_nxt = (out_xfer && delivered != '1) ? delivered + 1'b1 : delivered;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      delivered <= '0;
      dst_err <= 1'b0;
      done <= 1'b0;
    end else begin
      valid_out <= in_xfer || (valid_out && !ready_in);
      delivered <= cnt_nxt;
      done <= done || (32'(cnt_nxt) >= 32'(DONE_COUNT));
      if (in_xfer) begin
        data_out <= sel;
        ptr <= g == PW'(NIN - 1) ? '0 : g + 1'b1;
        dst_err <= dst_err || (sel[WIDTH-1-N_ADDR_WIDTH -: N_ADDR_WIDTH] != N_ADDR_WIDTH'(NODE));
      end
    end
  end
endmodule

// File: tb/tb_sink_rr_arbiter.sv
// tb_sink_rr_arbiter: directed and randomized checks of sink_rr_arbiter against a cycle-level reference model
module tb_sink_rr_arbiter;
  localparam int W = 32, NIN = 4, NODE = 15, CW = 4, DC = 5;
  logic clk = 1'b0, rst = 1'b1, ready_in = 1'b0;
  logic [NIN*W-1:0] data_in = '0;
  logic [NIN-1:0] valid_in = '0, ready_out;
  logic [W-1:0] data_out;
  logic valid_out, dst_err, done;
  logic [CW-1:0] delivered;
  int checks = 0, failures = 0, seq = 0;
  bit m_full = 0, m_err = 0, m_done = 0;
  logic [W-1:0] m_data = '0;
  int m_ptr = 0, m_cnt = 0;
  logic [W-1:0] held;
  always #5 clk = ~clk;
  sink_rr_arbiter #(.WIDTH(W), .N(16), .NIN(NIN), .NODE(NODE), .CNT_WIDTH(CW), .DONE_COUNT(DC)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .delivered(delivered), .dst_err(dst_err), .done(done)
  );
  function automatic logic [W-1:0] mk(int src, int dst, int id, int pay);
    return {4'(src), 4'(dst), 8'(id), 16'(pay)};
  endfunction
  function automatic int mgrant();
    if (rst || (m_full && !ready_in)) return -1;
    for (int k = 0; k < NIN; k++)
      if (valid_in[2'((m_ptr + k) % NIN)]) return (m_ptr + k) % NIN;
    return -1;
  endfunction
  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_all(int dst);
    for (int i = 0; i < NIN; i++) begin
      data_in[i*W +: W] = mk(i, dst, seq, $urandom_range(0, 65535));
      seq++;
    end
  endtask
  task automatic cycle();
    int g;
    bit ox;
    @(negedge clk);
    g = mgrant();
    chk("ready_out", W'(ready_out), (g < 0) ? W'(0) : W'(1) << g);
    chk("valid_out", W'(valid_out), W'(m_full));
    chk("data_out", data_out, m_data);
    chk("delivered", W'(delivered), W'(m_cnt));
    chk("dst_err", W'(dst_err), W'(m_err));
    chk("done", W'(done), W'(m_done));
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_err = 0; m_done = 0; m_data = '0; m_ptr = 0; m_cnt = 0;
    end else begin
      g = mgrant();
      ox = m_full && ready_in;
      if (ox && m_cnt < (1 << CW) - 1) m_cnt++;
      if (g >= 0) begin
        m_data = data_in[g*W +: W];
        m_full = 1;
        m_ptr = (g + 1) % NIN;
        if (m_data[27:24] != 4'(NODE)) m_err = 1;
      end else if (ox) m_full = 0;
      if (m_cnt >= DC) m_done = 1;
    end
    #1;
  endtask
  initial begin
    // reset with every input requesting: nothing may be granted
    valid_in = '1;
    set_all(NODE);
    cycle();
    cycle();
    chk("rst_ready_zero", W'(ready_out), W'(0));
    chk("rst_valid_out", W'(valid_out), W'(0));
    chk("rst_delivered", W'(delivered), W'(0));
    // fairness: all valid, sink always ready
    rst = 1'b0;
    ready_in = 1'b1;
    for (int c = 0; c < 13; c++) begin
      set_all(NODE);
      cycle();
      chk("fair_src", W'(data_out[31:28]), W'(c % NIN));
      chk("fair_done", W'(done), W'(c >= DC));
    end
    chk("fair_delivered", W'(delivered), W'(12));
    valid_in = '0;
    cycle();
    cycle();
    chk("done_sticky", W'(done), W'(1));
    chk("idle_delivered", W'(delivered), W'(13));
    // reset while a flit is buffered
    valid_in = '1;
    set_all(NODE);
    cycle();
    chk("pre_rst_valid", W'(valid_out), W'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    valid_in = 4'b1010;
    #1;
    chk("post_rst_valid", W'(valid_out), W'(0));
    chk("post_rst_delivered", W'(delivered), W'(0));
    chk("post_rst_done", W'(done), W'(0));
    chk("post_rst_dst_err", W'(dst_err), W'(0));
    chk("post_rst_first_grant", W'(ready_out), W'(4'b0010));
    cycle();
    // single requester
    valid_in = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      set_all(NODE);
      #1;
      chk("only2_ready", W'(ready_out), W'(4'b0100));
      cycle();
      chk("only2_src", W'(data_out[31:28]), W'(2));
    end
    // backpressure
    valid_in = '0;
    cycle();
    valid_in = 4'b0011;
    ready_in = 1'b0;
    #1;
    chk("bp_first_grant", W'(ready_out), W'(4'b0001));
    cycle();
    held = data_out;
    chk("bp_src0", W'(data_out[31:28]), W'(0));
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_ready_zero", W'(ready_out), W'(0));
      cycle();
      chk("bp_hold", data_out, held);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_release_grant", W'(ready_out), W'(4'b0010));
    cycle();
    chk("bp_src1", W'(data_out[31:28]), W'(1));
    // misrouted flit
    valid_in = 4'b0001;
    data_in[0 +: W] = mk(0, 3, 200, 1234);
    chk("pre_err", W'(dst_err), W'(0));
    cycle();
    chk("dst_err_set", W'(dst_err), W'(1));
    valid_in = '1;
    for (int c = 0; c < 4; c++) begin
      set_all(NODE);
      cycle();
    end
    chk("dst_err_sticky", W'(dst_err), W'(1));
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      valid_in = NIN'($urandom);
      ready_in = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NIN; i++)
        data_in[i*W +: W] = mk(i, ($urandom_range(0, 19) == 0) ? $urandom_range(0, 15) : NODE,
                               $urandom_range(0, 255), $urandom_range(0, 65535));
      cycle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
